id_ex_stage: RTL and testbench

- Registered ID/EX pipeline stage and the producer of the execute-stage operand mux inputs.
- Decodes the 32-bit LEGv8 instruction into control signals and a 64-bit extended immediate.
- Captures register-file read data and PC, then presents data2, signext and alusrc (plus other controls) to the EX stage.
- Valid/ready handshake on both sides, with flush support.

---
 rtl/id_ex_if.sv | 50 +++++
 rtl/id_ex_stage.sv | 153 +++++++++++++++
 tb/tb_id_ex_stage.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// ID/EX handshake and operand bundle between decode, the ID/EX register and EX.
// The optional ID_EX_PERF_EN counters are plain ports on id_ex_stage, not part of this bundle.
interface id_ex_if #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ex_data1;
  logic [DATA_W-1:0] ex_data2;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] ex_signext;
  logic              ex_alusrc;
  logic [1:0]        ex_aluop;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_memtoreg;
  logic              ex_branch;
  logic              ex_ubranch;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_illegal;

  modport master (
    output in_valid, instr, pc, rd_data1, rd_data2,
    output flush, out_ready,
    input  in_ready, out_valid,
    input  ex_data1, ex_data2, ex_pc, ex_signext,
    input  ex_alusrc, ex_aluop, ex_regwrite, ex_memread,
    input  ex_memwrite, ex_memtoreg, ex_branch, ex_ubranch,
    input  ex_rd, ex_illegal
  );

  modport slave (
    input  in_valid, instr, pc, rd_data1, rd_data2,
    input  flush, out_ready,
    output in_ready, out_valid,
    output ex_data1, ex_data2, ex_pc, ex_signext,
    output ex_alusrc, ex_aluop, ex_regwrite, ex_memread,
    output ex_memwrite, ex_memtoreg, ex_branch, ex_ubranch,
    output ex_rd, ex_illegal
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with LEGv8 decode and immediate extension.
// Define ID_EX_PERF_EN to add saturating stall_cnt/flush_cnt outputs.
module id_ex_stage #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  id_ex_if.slave bus
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef struct packed {
    logic       alusrc;
    logic [1:0] aluop;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       branch;
    logic       ubranch;
    logic       illegal;
  } ctrl_t;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  logic [31:0]       ins;
  logic [10:0]       op11;
  ctrl_t             dec;
  logic [DATA_W-1:0] imm;

  ctrl_t             ctrl_q;
  logic              valid_q;
  logic [DATA_W-1:0] d1_q;
  logic [DATA_W-1:0] d2_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] imm_q;
  logic [REG_AW-1:0] rd_q;

  assign ins  = bus.instr;
  assign op11 = ins[31:21];

  // Opcode classes never overlap, so the match order is free.
  always_comb begin
    dec = '0;
    imm = '0;
    unique case (1'b1)
      (op11 == OP_LDUR): begin
        dec.alusrc   = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwrite = 1'b1;
        imm = {{(DATA_W-9){ins[20]}}, ins[20:12]};
      end
      (op11 == OP_STUR): begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        imm = {{(DATA_W-9){ins[20]}}, ins[20:12]};
      end
      (op11 == OP_ADD || op11 == OP_SUB ||
       op11 == OP_AND || op11 == OP_ORR): begin
        dec.aluop    = 2'b10;
        dec.regwrite = 1'b1;
      end
      (ins[31:22] == OP_ADDI): begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        imm = {{(DATA_W-12){1'b0}}, ins[21:10]};
      end
      (ins[31:24] == OP_CBZ): begin
        dec.aluop  = 2'b01;
        dec.branch = 1'b1;
        imm = {{(DATA_W-19){ins[23]}}, ins[23:5]};
      end
      (ins[31:26] == OP_B): begin
        dec.ubranch = 1'b1;
        imm = {{(DATA_W-26){ins[25]}}, ins[25:0]};
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign bus.in_ready = !valid_q || bus.out_ready;

  // Controls are cleared with valid so a bubble never carries live controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (bus.in_ready) begin
      valid_q <= bus.in_valid;
      ctrl_q  <= bus.in_valid ? dec : '0;
      if (bus.in_valid) begin
        d1_q  <= bus.rd_data1;
        d2_q  <= bus.rd_data2;
        pc_q  <= bus.pc;
        imm_q <= imm;
        rd_q  <= ins[REG_AW-1:0];
      end
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.ex_data1    = d1_q;
  assign bus.ex_data2    = d2_q;
  assign bus.ex_pc       = pc_q;
  assign bus.ex_signext  = imm_q;
  assign bus.ex_rd       = rd_q;
  assign bus.ex_alusrc   = ctrl_q.alusrc;
  assign bus.ex_aluop    = ctrl_q.aluop;
  assign bus.ex_regwrite = ctrl_q.regwrite;
  assign bus.ex_memread  = ctrl_q.memread;
  assign bus.ex_memwrite = ctrl_q.memwrite;
  assign bus.ex_memtoreg = ctrl_q.memtoreg;
  assign bus.ex_branch   = ctrl_q.branch;
  assign bus.ex_ubranch  = ctrl_q.ubranch;
  assign bus.ex_illegal  = ctrl_q.illegal;

`ifdef ID_EX_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (valid_q && !bus.out_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (bus.flush && (valid_q || bus.in_valid) && flush_cnt != '1)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and random stimulus for id_ex_stage with a scoreboard queue.
// Build with +define+ID_EX_PERF_EN to also check the perf counters.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_if #(.DATA_W(64), .REG_AW(5)) bus ();

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  id_ex_stage #(.DATA_W(64), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ID_EX_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  typedef struct packed {
    logic [63:0] d1;
    logic [63:0] d2;
    logic [63:0] pc;
    logic [63:0] imm;
    logic        alusrc;
    logic [1:0]  aluop;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        mtr;
    logic        br;
    logic        ub;
    logic [4:0]  rd;
    logic        ill;
  } obs_t;

  obs_t q[$];
  int total = 0;
  int bad = 0;

  localparam logic [31:0] I_LDUR = 32'hF85F8041;
  localparam logic [31:0] I_ADD  = 32'h8B020023;
  localparam logic [31:0] I_ADDI = 32'h913FFC21;
  localparam logic [31:0] I_CBZ  = 32'hB4FFFF85;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;
  localparam logic [31:0] I_STUR = {11'b11111000000, 9'h1F0, 2'b00, 5'd2, 5'd3};
  localparam logic [31:0] I_B    = {6'b000101, 26'h3FFFFFE};

  function automatic obs_t model(logic [31:0] i, logic [63:0] p,
                                 logic [63:0] a, logic [63:0] b);
    obs_t e;
    logic signed [63:0] s;
    e = '0;
    e.d1 = a;
    e.d2 = b;
    e.pc = p;
    e.rd = i[4:0];
    if (i[31:21] == 11'b11111000010) begin
      s = $signed(i[20:12]);
      e.imm = s; e.alusrc = 1; e.mr = 1; e.mtr = 1; e.rw = 1;
    end else if (i[31:21] == 11'b11111000000) begin
      s = $signed(i[20:12]);
      e.imm = s; e.alusrc = 1; e.mw = 1;
    end else if (i[31:21] == 11'b10001011000 || i[31:21] == 11'b11001011000 ||
                 i[31:21] == 11'b10001010000 || i[31:21] == 11'b10101010000) begin
      e.aluop = 2'b10; e.rw = 1;
    end else if (i[31:22] == 10'b1001000100) begin
      e.imm = {52'd0, i[21:10]}; e.alusrc = 1; e.rw = 1;
    end else if (i[31:24] == 8'b10110100) begin
      s = $signed(i[23:5]);
      e.imm = s; e.aluop = 2'b01; e.br = 1;
    end else if (i[31:26] == 6'b000101) begin
      s = $signed(i[25:0]);
      e.imm = s; e.ub = 1;
    end else begin
      e.ill = 1;
    end
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.d1 = bus.ex_data1;  o.d2 = bus.ex_data2;
    o.pc = bus.ex_pc;     o.imm = bus.ex_signext;
    o.alusrc = bus.ex_alusrc; o.aluop = bus.ex_aluop;
    o.rw = bus.ex_regwrite;   o.mr = bus.ex_memread;
    o.mw = bus.ex_memwrite;   o.mtr = bus.ex_memtoreg;
    o.br = bus.ex_branch;     o.ub = bus.ex_ubranch;
    o.rd = bus.ex_rd;         o.ill = bus.ex_illegal;
    return o;
  endfunction

  function automatic logic [9:0] ctrl();
    return {bus.ex_alusrc, bus.ex_aluop, bus.ex_regwrite, bus.ex_memread,
            bus.ex_memwrite, bus.ex_memtoreg, bus.ex_branch, bus.ex_ubranch,
            bus.ex_illegal};
  endfunction

  task automatic chk(string tag, logic [270:0] o, logic [270:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic step(bit iv, logic [31:0] ins, logic [63:0] p,
                      logic [63:0] a, logic [63:0] b, bit ordy, bit fl);
    bit held;
    bus.in_valid = iv; bus.instr = ins; bus.pc = p;
    bus.rd_data1 = a;  bus.rd_data2 = b;
    bus.out_ready = ordy; bus.flush = fl;
    #1;
    held = (q.size() != 0);
    chk("in_ready", 271'(bus.in_ready), 271'(!held || ordy));
    chk("out_valid", 271'(bus.out_valid), 271'(held));
    if (bus.out_valid && held) begin
      if (fl) void'(q.pop_front());
      else begin
        chk("ex_out", sample(), q[0]);
        if (ordy) void'(q.pop_front());
      end
    end else if (!bus.out_valid) begin
      chk("idle_ctrl", 271'(ctrl()), 271'(0));
    end
    if (iv && (!held || ordy) && !fl) q.push_back(model(ins, p, a, b));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] ins;
    rst_n = 1'b0;
    bus.in_valid = 1; bus.instr = I_LDUR; bus.pc = 64'h100;
    bus.rd_data1 = 64'h11; bus.rd_data2 = 64'h22;
    bus.out_ready = 1; bus.flush = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 271'(bus.out_valid), 271'(0));
    chk("rst_outs", sample(), 271'(0));
    rst_n = 1'b1;

    step(1, I_LDUR, 64'h100, 64'h11, 64'h22, 1, 0);
    chk("ldur_imm", 271'(bus.ex_signext), 271'(64'hFFFF_FFFF_FFFF_FFF8));
    chk("ldur_ctrl", 271'(ctrl()), 271'(10'b1_00_110100_0));
    chk("ldur_rd", 271'(bus.ex_rd), 271'(1));

    step(1, I_ADD, 64'h104, 64'h5, 64'h1234, 1, 0);
    chk("add_d2", 271'(bus.ex_data2), 271'(64'h1234));
    chk("add_ctrl", 271'(ctrl()), 271'(10'b0_10_100000_0));
    chk("add_imm", 271'(bus.ex_signext), 271'(0));

    step(1, I_ADDI, 64'h108, 64'h1, 64'h2, 1, 0);
    chk("addi_imm", 271'(bus.ex_signext), 271'(64'hFFF));
    chk("addi_src", 271'(bus.ex_alusrc), 271'(1));

    step(1, I_CBZ, 64'h10C, 64'h3, 64'h4, 1, 0);
    chk("cbz_imm", 271'(bus.ex_signext), 271'(64'hFFFF_FFFF_FFFF_FFFC));
    chk("cbz_ctrl", 271'(ctrl()), 271'(10'b0_01_000010_0));

    step(1, I_BAD, 64'h110, 64'h5, 64'h6, 1, 0);
    chk("bad_ctrl", 271'(ctrl()), 271'(10'b0_00_000000_1));

    step(1, I_STUR, 64'h114, 64'h7, 64'h8, 1, 0);
    step(1, I_B, 64'h118, 64'h9, 64'hA, 1, 0);
    chk("b_imm", 271'(bus.ex_signext), 271'(64'hFFFF_FFFF_FFFF_FFFE));

    // Stall: B held by EX for three cycles while ADD waits at the input.
    step(1, I_ADD, 64'h11C, 64'hB, 64'hC, 0, 0);
    step(1, I_ADD, 64'h11C, 64'hB, 64'hC, 0, 0);
    step(1, I_ADD, 64'h11C, 64'hB, 64'hC, 0, 0);
`ifdef ID_EX_PERF_EN
    chk("stall_cnt", 271'(stall_cnt), 271'(3));
`endif
    step(1, I_ADD, 64'h11C, 64'hB, 64'hC, 1, 0);
    step(1, I_STUR, 64'h120, 64'hD, 64'hE, 1, 0);

    // Flush with a held STUR and an incoming ADD in the same cycle.
    step(1, I_ADD, 64'h124, 64'hF, 64'h10, 0, 1);
    chk("fl_valid", 271'(bus.out_valid), 271'(0));
    chk("fl_ctrl", 271'({bus.ex_regwrite, bus.ex_memwrite}), 271'(0));
`ifdef ID_EX_PERF_EN
    chk("flush_cnt", 271'(flush_cnt), 271'(1));
`endif

    for (int k = 0; k < 40; k++) begin
      r = $urandom;
      case ($urandom_range(0, 9))
        0: ins = {11'b11111000010, r[20:0]};
        1: ins = {11'b11111000000, r[20:0]};
        2: ins = {11'b11001011000, r[20:0]};
        3: ins = {11'b10001010000, r[20:0]};
        4: ins = {11'b10101010000, r[20:0]};
        5: ins = {10'b1001000100, r[21:0]};
        6: ins = {8'b10110100, r[23:0]};
        7: ins = {6'b000101, r[25:0]};
        default: ins = r;
      endcase
      step($urandom_range(0, 3) != 0, ins, {32'd0, $urandom},
           {$urandom, $urandom}, {$urandom, $urandom},
           $urandom_range(0, 2) != 0, 0);
    end

    repeat (3) step(0, 32'd0, 64'd0, 64'd0, 64'd0, 1, 0);
    chk("sb_drained", 271'(q.size()), 271'(0));

    // Asynchronous reset while an instruction is held.
    step(1, I_LDUR, 64'h200, 64'h1, 64'h2, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 271'(bus.out_valid), 271'(0));
    chk("arst_ctrl", 271'(ctrl()), 271'(0));
`ifdef ID_EX_PERF_EN
    chk("arst_cnt", 271'({stall_cnt, flush_cnt}), 271'(0));
`endif
    q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
